// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// RV64I opcodes, ALU operation codes and datapath mux select codes.
package ctrl_pkg;

  typedef enum logic [4:0] {
    RESET    = 5'd0,
    FETCH    = 5'd1,
    FWAIT    = 5'd2,
    DECODE   = 5'd3,
    EXEC_R   = 5'd4,
    EXEC_I   = 5'd5,
    WB_ALU   = 5'd6,
    ADDR     = 5'd7,
    MEM_RD   = 5'd8,
    MEM_WAIT = 5'd9,
    WB_LOAD  = 5'd10,
    MEM_WR   = 5'd11,
    BRANCH   = 5'd12,
    JAL      = 5'd13,
    LUI      = 5'd14,
    HALT     = 5'd15
  } ctrlState_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_INC  = 3'd4;
  localparam logic [2:0] ALU_NOT  = 3'd5;
  localparam logic [2:0] ALU_XOR  = 3'd6;
  localparam logic [2:0] ALU_CMP  = 3'd7;

  localparam logic [2:0] MUXA_PC    = 3'd0;
  localparam logic [2:0] MUXA_REGA  = 3'd1;
  localparam logic [2:0] MUXA_OLDPC = 3'd2;

  localparam logic [2:0] MUXB_REGB  = 3'd0;
  localparam logic [2:0] MUXB_FOUR  = 3'd1;
  localparam logic [2:0] MUXB_SIGN  = 3'd2;
  localparam logic [2:0] MUXB_SHIFT = 3'd3;

  localparam logic [2:0] MUXMEM_ALUOUT = 3'd0;
  localparam logic [2:0] MUXMEM_LOAD   = 3'd1;
  localparam logic [2:0] MUXMEM_PC     = 3'd2;
  localparam logic [2:0] MUXMEM_IMM    = 3'd3;

endpackage

// File: rtl/ctrl_multiciclo.sv
// Multicycle control FSM for the UP RV64I-subset datapath.
// Optional feature: define CTRL_BLT_BGE_EN to decode BLT/BGE (funct3 100/101).
module ctrl_multiciclo
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i6_0,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       AluZero,
  input  logic       AluIgual,
  input  logic       AluMenor,
  output logic       PCwrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemData_Write,
  output logic       RegWrite,
  output logic       loadRegA,
  output logic       loadRegB,
  output logic       loadRegMemData,
  output logic       loadRegAluOut,
  output logic [2:0] SelMuxA,
  output logic [2:0] SelMuxB,
  output logic [2:0] SelMuxMem,
  output logic       SelMuxPC,
  output logic       SelMuxAlu,
  output logic [2:0] AluOperation,
  output logic [1:0] Shift,
  output logic [2:0] LoadTYPE,
  output logic [4:0] state,
  output logic       halted
);

  localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

  ctrlState_t curState, nxtState;
  logic [1:0] waitCnt;
  logic       waitLast;
  logic       inWait;
  logic       taken;
  logic       unusedFlags;

  assign waitLast = (waitCnt == WAIT_LAST);
  assign inWait   = (curState == FWAIT) || (curState == MEM_WAIT);
  assign state    = curState;

  // State register plus the memory-latency counter shared by both wait states
  always_ff @(posedge clk) begin
    if (rst) begin
      curState <= RESET;
      waitCnt  <= 2'd0;
    end else begin
      curState <= nxtState;
      waitCnt  <= (inWait && !waitLast) ? waitCnt + 2'd1 : 2'd0;
    end
  end

  // Branch condition evaluated from the live ALU flags in the BRANCH cycle
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = AluIgual;
      3'b001:  taken = !AluIgual;
`ifdef CTRL_BLT_BGE_EN
      3'b100:  taken = AluMenor;
      3'b101:  taken = !AluMenor;
`endif
      default: taken = 1'b0;
    endcase
  end

`ifdef CTRL_BLT_BGE_EN
  assign unusedFlags = AluZero;
`else
  assign unusedFlags = AluZero ^ AluMenor;
`endif

  // Next-state decode
  always_comb begin
    nxtState = curState;
    case (curState)
      RESET:    nxtState = FETCH;
      FETCH:    nxtState = FWAIT;
      FWAIT:    nxtState = waitLast ? DECODE : FWAIT;
      DECODE: begin
        case (i6_0)
          OP_RTYPE:          nxtState = EXEC_R;
          OP_ITYPE:          nxtState = EXEC_I;
          OP_LOAD, OP_STORE: nxtState = ADDR;
          OP_BRANCH:         nxtState = BRANCH;
          OP_JAL:            nxtState = JAL;
          OP_LUI:            nxtState = LUI;
          default:           nxtState = HALT;
        endcase
      end
      EXEC_R:   nxtState = WB_ALU;
      EXEC_I:   nxtState = WB_ALU;
      WB_ALU:   nxtState = FETCH;
      ADDR:     nxtState = (i6_0 == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   nxtState = MEM_WAIT;
      MEM_WAIT: nxtState = waitLast ? WB_LOAD : MEM_WAIT;
      WB_LOAD:  nxtState = FETCH;
      MEM_WR:   nxtState = FETCH;
      BRANCH:   nxtState = FETCH;
      JAL:      nxtState = FETCH;
      LUI:      nxtState = FETCH;
      HALT:     nxtState = HALT;
      default:  nxtState = RESET;
    endcase
  end

  // Output decode: everything low unless the current state names it
  always_comb begin
    PCwrite        = 1'b0;
    PCWriteCond    = 1'b0;
    IRWrite        = 1'b0;
    MemRead        = 1'b0;
    MemData_Write  = 1'b0;
    RegWrite       = 1'b0;
    loadRegA       = 1'b0;
    loadRegB       = 1'b0;
    loadRegMemData = 1'b0;
    loadRegAluOut  = 1'b0;
    SelMuxA        = MUXA_PC;
    SelMuxB        = MUXB_REGB;
    SelMuxMem      = MUXMEM_ALUOUT;
    SelMuxPC       = 1'b0;
    SelMuxAlu      = 1'b0;
    AluOperation   = ALU_PASS;
    Shift          = 2'd0;
    LoadTYPE       = 3'd0;
    halted         = 1'b0;
    case (curState)
      FETCH: MemRead = 1'b1;
      FWAIT: begin
        // PC <= PC + 4 together with the IR load, only once data is valid
        if (waitLast) begin
          IRWrite      = 1'b1;
          PCwrite      = 1'b1;
          SelMuxB      = MUXB_FOUR;
          AluOperation = ALU_ADD;
        end
      end
      DECODE: begin
        // Speculative branch/JAL target from the PC of this instruction
        loadRegA      = 1'b1;
        loadRegB      = 1'b1;
        loadRegAluOut = 1'b1;
        SelMuxA       = MUXA_OLDPC;
        SelMuxB       = MUXB_SHIFT;
        AluOperation  = ALU_ADD;
      end
      EXEC_R: begin
        loadRegAluOut = 1'b1;
        SelMuxA       = MUXA_REGA;
        AluOperation  = funct7_5 ? ALU_SUB : ALU_ADD;
      end
      EXEC_I: begin
        loadRegAluOut = 1'b1;
        SelMuxA       = MUXA_REGA;
        SelMuxB       = MUXB_SIGN;
        AluOperation  = ALU_ADD;
      end
      WB_ALU: RegWrite = 1'b1;
      ADDR: begin
        loadRegAluOut = 1'b1;
        SelMuxA       = MUXA_REGA;
        SelMuxB       = MUXB_SIGN;
        AluOperation  = ALU_ADD;
      end
      MEM_RD:   MemRead = 1'b1;
      MEM_WAIT: loadRegMemData = waitLast;
      WB_LOAD: begin
        RegWrite  = 1'b1;
        SelMuxMem = MUXMEM_LOAD;
        LoadTYPE  = funct3;
      end
      MEM_WR: MemData_Write = 1'b1;
      BRANCH: begin
        PCWriteCond  = 1'b1;
        SelMuxA      = MUXA_REGA;
        AluOperation = ALU_CMP;
        PCwrite      = taken;
        SelMuxPC     = taken;
      end
      JAL: begin
        RegWrite  = 1'b1;
        SelMuxMem = MUXMEM_PC;
        PCwrite   = 1'b1;
        SelMuxPC  = 1'b1;
      end
      LUI: begin
        RegWrite  = 1'b1;
        SelMuxMem = MUXMEM_IMM;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule
